// File: rtl/stb_arb_drain_ctrl.sv
// Store-buffer control: round-robin write arbitration across LSU store ports,
// circular read/write pointers with occupancy tracking, and a drain FSM that
// pushes the head entry to the dcache in the background or on a flush.
module stb_arb_drain_ctrl #(
    parameter int NUM_PORTS    = 2,
    parameter int DEPTH        = 8,
    parameter int DRAIN_THRESH = 4,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NUM_PORTS-1:0] lsummu2stb_req,
    input  logic [NUM_PORTS-1:0] lsummu2stb_w_en,
    input  logic [NUM_PORTS-1:0] dmem_sel_i,
    input  logic                 flush_i,
    input  logic                 dcache2stb_ack,
    output logic [NUM_PORTS-1:0] stb2lsummu_ack,
    output logic [NUM_PORTS-1:0] stb2lsummu_stall,
    output logic                 stb_wr_en,
    output logic [PW-1:0]        stb_wr_port,
    output logic [AW-1:0]        stb_wr_ptr,
    output logic [AW-1:0]        stb_rd_ptr,
    output logic                 stb2dcache_req,
    output logic [AW:0]          stb_count,
    output logic                 stb_full,
    output logic                 stb_empty,
    output logic                 stb_flush_done
);

    typedef enum logic [1:0] {D_IDLE, D_DRAIN, D_FLUSH} drain_state_e;

    drain_state_e         state_q, state_d;
    logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [AW:0]          count_q, count_d;
    logic [PW-1:0]        start_q, start_d;
    logic [NUM_PORTS-1:0] ack_q;

    logic [NUM_PORTS-1:0] valid;
    logic [NUM_PORTS-1:0] grant_vec;
    logic [PW-1:0]        grant_idx;
    logic                 grant_any;
    logic                 grant_en;
    logic [PW:0]          cand_sum;
    logic [PW-1:0]        cand_idx;
    logic                 full;
    logic                 drain_req;
    logic                 retire;
    logic                 flush_done;

    // A port that was acked this cycle is masked: its requester drops req now.
    // Everything is gated by rst_n so outputs read as idle while in reset.
    generate
        for (genvar gi = 0; gi < NUM_PORTS; gi++) begin : g_valid
            assign valid[gi] = rst_n & lsummu2stb_req[gi] & lsummu2stb_w_en[gi]
                             & dmem_sel_i[gi] & ~ack_q[gi];
        end
    endgenerate

    // A full buffer blocks grants even if the head retires this same cycle.
    assign full      = (count_q == (AW+1)'(DEPTH));
    assign grant_en  = rst_n & ~full & (state_q != D_FLUSH);
    assign drain_req = rst_n & ((state_q == D_DRAIN) | (state_q == D_FLUSH)) & (count_q != '0);
    assign retire    = drain_req & dcache2stb_ack;

    // Round-robin search beginning at the port after the last one granted.
    always_comb begin
        grant_vec = '0;
        grant_idx = '0;
        grant_any = 1'b0;
        cand_sum  = '0;
        cand_idx  = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            cand_sum = {1'b0, start_q} + (PW+1)'(k);
            if (cand_sum >= (PW+1)'(NUM_PORTS)) begin
                cand_sum = cand_sum - (PW+1)'(NUM_PORTS);
            end
            cand_idx = cand_sum[PW-1:0];
            if (!grant_any && grant_en && valid[cand_idx]) begin
                grant_any           = 1'b1;
                grant_vec[cand_idx] = 1'b1;
                grant_idx           = cand_idx;
            end
        end
    end

    // Pointer, occupancy and round-robin next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        start_d  = start_q;
        if (grant_any) begin
            wr_ptr_d = (wr_ptr_q == AW'(DEPTH-1)) ? '0 : wr_ptr_q + 1'b1;
            start_d  = (grant_idx == PW'(NUM_PORTS-1)) ? '0 : grant_idx + 1'b1;
        end
        if (retire) begin
            rd_ptr_d = (rd_ptr_q == AW'(DEPTH-1)) ? '0 : rd_ptr_q + 1'b1;
        end
        if (grant_any && !retire) begin
            count_d = count_q + 1'b1;
        end else if (!grant_any && retire) begin
            count_d = count_q - 1'b1;
        end
    end

    // Drain FSM next-state; flush_done is a single-cycle pulse on leaving D_FLUSH.
    always_comb begin
        state_d    = state_q;
        flush_done = 1'b0;
        case (state_q)
            D_IDLE: begin
                if (flush_i) begin
                    state_d = D_FLUSH;
                end else if (count_q >= (AW+1)'(DRAIN_THRESH)) begin
                    state_d = D_DRAIN;
                end
            end
            D_DRAIN: begin
                if (flush_i) begin
                    state_d = D_FLUSH;
                end else if (count_d == '0) begin
                    state_d = D_IDLE;
                end
            end
            D_FLUSH: begin
                if (count_q == '0) begin
                    flush_done = 1'b1;
                    state_d    = D_IDLE;
                end
            end
            default: state_d = D_IDLE;
        endcase
    end

    // State registers; the store-accepted pulse trails the grant by one cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= D_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            start_q  <= '0;
            ack_q    <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            start_q  <= start_d;
            ack_q    <= grant_vec;
        end
    end

    assign stb2lsummu_ack   = ack_q & {NUM_PORTS{rst_n}};
    assign stb2lsummu_stall = valid & ~grant_vec;
    assign stb_wr_en        = grant_any;
    assign stb_wr_port      = grant_idx;
    assign stb_wr_ptr       = rst_n ? wr_ptr_q : '0;
    assign stb_rd_ptr       = rst_n ? rd_ptr_q : '0;
    assign stb2dcache_req   = drain_req;
    assign stb_count        = rst_n ? count_q : '0;
    assign stb_full         = rst_n & full;
    assign stb_empty        = ~rst_n | (count_q == '0);
    assign stb_flush_done   = rst_n & flush_done;

endmodule
